// File: rtl/loctag_mode_ctrl.sv
// Key/mode debouncer and decoder with a mode-count status LED.
// Define LOCTAG_MODE_BLINK_EN to build the blink FSM; otherwise led follows cfg_valid.
//
//   state | meaning
//   GAP   | led off for 4*BLINK_CYCLES, pulse count cleared
//   ON    | led on for BLINK_CYCLES
//   OFF   | led off for BLINK_CYCLES, then ON again until mode+1 pulses shown
module loctag_mode_ctrl #(
    parameter int NUM_KEYS        = 4,
    parameter int MODE_W          = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BLINK_CYCLES    = 5000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_KEYS-1:0]          keys_n,
    input  logic                         ext_mode,
    output logic [MODE_W-1:0]            mode,
    output logic [NUM_KEYS-MODE_W-1:0]   mac_q,
    output logic                         cfg_valid,
    output logic                         cfg_changed,
    output logic                         led
);

    localparam int NIN   = NUM_KEYS + 1;
    localparam int MAC_W = NUM_KEYS - MODE_W;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int VLD_W = $clog2(DEBOUNCE_CYCLES + 3);

    localparam logic [NIN-1:0]   IDLE_VAL = {1'b0, {NUM_KEYS{1'b1}}};
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [VLD_W-1:0] VLD_LAST = VLD_W'(DEBOUNCE_CYCLES + 2);

    if (NUM_KEYS < 3 || NUM_KEYS > 8 || MODE_W < 1 || MODE_W >= NUM_KEYS ||
        DEBOUNCE_CYCLES < 2 || BLINK_CYCLES < 1) begin : g_param_check
        $error("loctag_mode_ctrl: parameter out of range");
    end

    logic [NIN-1:0]   raw_in;
    logic [NIN-1:0]   sync1_q;
    logic [NIN-1:0]   sync2_q;
    logic [NIN-1:0]   deb_q;
    logic [CNT_W-1:0] db_cnt_q [NIN];
    logic [VLD_W-1:0] vld_cnt_q;

    logic [MODE_W-1:0] mode_keys;
    logic [MODE_W-1:0] mode_nx;
    logic [MAC_W-1:0]  mac_nx;
    logic              cfg_change;

    // ext_mode rides along as the top bit so every input gets identical treatment
    assign raw_in = {ext_mode, keys_n};

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= IDLE_VAL;
            sync2_q <= IDLE_VAL;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            deb_q <= IDLE_VAL;
            for (int i = 0; i < NIN; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NIN; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    deb_q[i]    <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // cfg_valid marks the point where every input has had one full window to settle
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_cnt_q <= '0;
            cfg_valid <= 1'b0;
        end else if (!cfg_valid) begin
            if (vld_cnt_q == VLD_LAST) begin
                cfg_valid <= 1'b1;
            end else begin
                vld_cnt_q <= vld_cnt_q + VLD_W'(1);
            end
        end
    end

    always_comb begin
        mode_keys = ~deb_q[MODE_W-1:0];
        if (|mode_keys) begin
            mode_nx = mode_keys;
        end else if (deb_q[NUM_KEYS]) begin
            mode_nx = '1;
        end else begin
            mode_nx = '0;
        end
        mac_nx     = ~deb_q[NUM_KEYS-1:MODE_W];
        cfg_change = cfg_valid && ({mode_nx, mac_nx} != {mode, mac_q});
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode        <= '0;
            mac_q       <= '0;
            cfg_changed <= 1'b0;
        end else begin
            mode        <= mode_nx;
            mac_q       <= mac_nx;
            cfg_changed <= cfg_change;
        end
    end

`ifdef LOCTAG_MODE_BLINK_EN
    typedef enum logic [1:0] {
        S_GAP = 2'd0,
        S_ON  = 2'd1,
        S_OFF = 2'd2
    } led_state_t;

    localparam int TMR_W = $clog2(4 * BLINK_CYCLES + 1);
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(4 * BLINK_CYCLES - 1);
    localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(BLINK_CYCLES - 1);

    led_state_t        state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [MODE_W:0]   pulse_q, pulse_d;
    logic [MODE_W:0]   pulse_target;

    assign pulse_target = {1'b0, mode} + {{MODE_W{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_GAP;
            timer_q <= '0;
            pulse_q <= '0;
            led     <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pulse_q <= pulse_d;
            led     <= (state_d == S_ON);
        end
    end

    // A config change restarts the display at the same edge the new mode lands
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pulse_d = pulse_q;
        if (!cfg_valid || cfg_change) begin
            state_d = S_GAP;
            timer_d = GAP_LAST;
            pulse_d = '0;
        end else if (timer_q != '0) begin
            timer_d = timer_q - TMR_W'(1);
        end else begin
            unique case (state_q)
                S_GAP: begin
                    state_d = S_ON;
                    timer_d = PULSE_LAST;
                end
                S_ON: begin
                    state_d = S_OFF;
                    timer_d = PULSE_LAST;
                    pulse_d = pulse_q + {{MODE_W{1'b0}}, 1'b1};
                end
                S_OFF: begin
                    if (pulse_q < pulse_target) begin
                        state_d = S_ON;
                        timer_d = PULSE_LAST;
                    end else begin
                        state_d = S_GAP;
                        timer_d = GAP_LAST;
                        pulse_d = '0;
                    end
                end
                default: begin
                    state_d = S_GAP;
                    timer_d = GAP_LAST;
                    pulse_d = '0;
                end
            endcase
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!reset) begin
            led <= 1'b0;
        end else begin
            led <= cfg_valid;
        end
    end
`endif

endmodule

// File: tb/tb_loctag_mode_ctrl.sv
// Randomised bench for loctag_mode_ctrl against a cycle-level behavioural model.
// Follows LOCTAG_MODE_BLINK_EN to choose the expected led behaviour.
module tb_loctag_mode_ctrl;
    localparam int NK = 4;
    localparam int MW = 2;
    localparam int D  = 4;
    localparam int B  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NK-1:0] keys_n = 4'hF;
    logic          ext_mode = 1'b0;
    logic [MW-1:0] mode;
    logic [NK-MW-1:0] mac_q;
    logic          cfg_valid;
    logic          cfg_changed;
    logic          led;

    loctag_mode_ctrl #(
        .NUM_KEYS(NK), .MODE_W(MW), .DEBOUNCE_CYCLES(D), .BLINK_CYCLES(B)
    ) dut (
        .clk(clk), .reset(reset), .keys_n(keys_n), .ext_mode(ext_mode),
        .mode(mode), .mac_q(mac_q), .cfg_valid(cfg_valid),
        .cfg_changed(cfg_changed), .led(led)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

`ifdef LOCTAG_MODE_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    // Model: inputs reach the debouncer two cycles late; a debounced value flips
    // after D consecutive cycles of disagreement; outputs follow one cycle later.
    logic [4:0] m_s1, m_s2, m_deb;
    int         m_run [5];
    int         m_vcnt;
    bit         m_valid, m_chg, m_led, m_init;
    logic [1:0] m_mode, m_mac;
    int         m_pos;

    task automatic model_step();
        logic [4:0] raw, deb_old;
        logic [1:0] mk, nm, nmac;
        bit valid_old;
        int period, p;
        if (!reset) begin
            m_s1 = 5'b01111; m_s2 = 5'b01111; m_deb = 5'b01111;
            for (int i = 0; i < 5; i++) m_run[i] = 0;
            m_vcnt = 0; m_valid = 0; m_chg = 0; m_led = 0;
            m_mode = 0; m_mac = 0; m_pos = 0; m_init = 1;
            return;
        end
        raw = {ext_mode, keys_n};
        deb_old = m_deb;
        valid_old = m_valid;
        for (int i = 0; i < 5; i++) begin
            if (m_s2[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_deb[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
        mk = ~deb_old[1:0];
        if (mk != 2'b00) nm = mk;
        else if (deb_old[4]) nm = 2'b11;
        else nm = 2'b00;
        nmac = ~deb_old[3:2];
        m_chg = valid_old && ({nm, nmac} != {m_mode, m_mac});
        m_mode = nm;
        m_mac = nmac;
        if (!m_valid) begin
            m_vcnt++;
            if (m_vcnt == D + 3) m_valid = 1;
        end
        if (BLINK) begin
            if (!m_valid || m_chg || !valid_old) begin
                m_pos = 0;
                m_led = 0;
            end else begin
                m_pos++;
                period = 4 * B + 2 * B * (int'(m_mode) + 1);
                p = m_pos % period;
                m_led = (p >= 4 * B) && (((p - 4 * B) / B) % 2 == 0);
            end
        end else begin
            m_led = valid_old;
        end
    endtask

    initial begin
        m_init = 0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("mode", int'(mode), int'(m_mode));
            chk("mac_q", int'(mac_q), int'(m_mac));
            chk("cfg_valid", int'(cfg_valid), int'(m_valid));
            chk("cfg_changed", int'(cfg_changed), int'(m_chg));
            chk("led", int'(led), int'(m_led));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int ons;

    initial begin
        reset = 1'b0;
        cyc(3);
        reset = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            cyc(1);
            if (i == 6) chk("valid_before_7", int'(cfg_valid), 0);
            if (i < 7) chk("no_pulse_startup", int'(cfg_changed), 0);
        end
        chk("valid_at_7", int'(cfg_valid), 1);
        chk("mode_idle", int'(mode), 0);
        chk("mac_idle", int'(mac_q), 0);

        keys_n = 4'b1101;
        cyc(6);
        chk("mode_before_7", int'(mode), 0);
        cyc(1);
        chk("mode_10", int'(mode), 2);
        chk("pulse_mode_10", int'(cfg_changed), 1);

        ons = int'(led);
        for (int k = 1; k < 20; k++) begin
            cyc(1);
            if (k == 1) chk("pulse_one_cycle", int'(cfg_changed), 0);
            if (k == 7) chk("led_gap_end", int'(led), BLINK ? 0 : 1);
            if (k == 8) chk("led_first_on", int'(led), 1);
            if (led) ons++;
        end
        chk("led_on_cycles", ons, BLINK ? 6 : 20);

        cyc(10);
        keys_n = 4'b0101;
        cyc(7);
        chk("mac_10", int'(mac_q), 2);
        chk("pulse_mac", int'(cfg_changed), 1);
        chk("led_restart", int'(led), BLINK ? 0 : 1);

        keys_n = 4'b0100;
        cyc(3);
        keys_n = 4'b0101;
        cyc(15);
        chk("glitch_mode", int'(mode), 2);

        keys_n = 4'hF;
        cyc(10);
        ext_mode = 1'b1;
        cyc(6);
        chk("ext_before_7", int'(mode), 0);
        cyc(1);
        chk("ext_mode_11", int'(mode), 3);
        cyc(5);
        keys_n = 4'b1110;
        cyc(7);
        chk("key_over_ext", int'(mode), 1);

        for (int it = 0; it < 300; it++) begin
            keys_n = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) ext_mode = ~ext_mode;
            cyc($urandom_range(1, 12));
        end
        keys_n = 4'b1101;
        ext_mode = 1'b0;
        cyc(40);

        reset = 1'b0;
        cyc(1);
        chk("rst_led", int'(led), 0);
        chk("rst_valid", int'(cfg_valid), 0);
        chk("rst_mode", int'(mode), 0);
        chk("rst_pulse", int'(cfg_changed), 0);
        reset = 1'b1;
        cyc(60);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/loctag_mode_ctrl.md
LOCTAG_MODE_CTRL -- requirements
Module: loctag_mode_ctrl

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4: number of active-low user keys; 3..8.
REQ-002 SHALL have parameter MODE_W, default 2: keys [MODE_W-1:0] select mode, keys [NUM_KEYS-1:MODE_W] form mac_q; 1..NUM_KEYS-1.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 50000: stability window in clk cycles (1 ms at 50 MHz); >=2.
REQ-004 SHALL have parameter BLINK_CYCLES, default 5000000: LED on/off half-period in clk cycles; >=1.
REQ-005 SHALL have port clk, input, 1: 50 MHz system clock, the block's only clock.
REQ-006 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port keys_n, input, NUM_KEYS: raw asynchronous key pins, 0 = pressed.
REQ-008 SHALL have port ext_mode, input, 1: raw asynchronous external mode-override pin, 1 = request.
REQ-009 SHALL have port mode, output, MODE_W: registered decoded mode.
REQ-010 SHALL have port mac_q, output, NUM_KEYS-MODE_W: registered MAC selection, 1 = key pressed.
REQ-011 SHALL have port cfg_valid, output, 1: high once the first full debounce window has elapsed.
REQ-012 SHALL have port cfg_changed, output, 1: one-cycle pulse on any mode or mac_q update.
REQ-013 SHALL have port led, output, 1: active-high status indicator.

Function
REQ-014 SHALL pass each of the NUM_KEYS+1 raw inputs through a 2-flop synchroniser before any other logic.
REQ-015 SHALL give each synchronised input its own counter, $clog2(DEBOUNCE_CYCLES+1) bits wide, which counts while the input differs from its debounced state and clears when they match.
REQ-016 SHALL take the new debounced value on the edge where the counter reaches DEBOUNCE_CYCLES-1 while the input still differs, so the debounced value changes DEBOUNCE_CYCLES+2 cycles after a stable raw edge.
REQ-017 SHALL ignore any glitch shorter than DEBOUNCE_CYCLES cycles: the counter clears and the debounced state is unchanged.
REQ-018 SHALL decode mode as follows: if any debounced mode key is pressed, mode = bitwise NOT of debounced keys_n[MODE_W-1:0]; else if debounced ext_mode = 1, mode = all ones; else mode = 0.
REQ-019 SHALL set mac_q = bitwise NOT of debounced keys_n[NUM_KEYS-1:MODE_W].
REQ-020 SHALL register mode and mac_q one cycle after the debounced change, so the total latency from a stable raw edge to the output is DEBOUNCE_CYCLES+3 cycles.
REQ-021 SHALL assert cfg_changed in the same cycle as the mode/mac_q update, only when the new value differs from the old value, and only while cfg_valid = 1.
REQ-022 SHALL treat simultaneous debounced changes on several inputs as a single update with a single cfg_changed pulse.
REQ-023 SHALL assert cfg_valid once DEBOUNCE_CYCLES+3 cycles have elapsed after reset is released, and hold it high until the next reset.
REQ-024 SHALL implement the LED FSM with three states: GAP (led=0, 4*BLINK_CYCLES cycles), ON (led=1, BLINK_CYCLES cycles), OFF (led=0, BLINK_CYCLES cycles).
REQ-025 SHALL sequence the LED FSM GAP->ON->OFF, then OFF->ON while the pulse count is below mode+1, otherwise OFF->GAP with the pulse count cleared.
REQ-026 SHALL force the LED FSM to GAP, clearing its timer and pulse count, on every cfg_changed pulse.
REQ-027 SHALL hold the LED FSM in GAP with led = 0 while cfg_valid = 0.
REQ-028 SHALL let the blink timer wrap only through FSM state change and never overflow its width, $clog2(4*BLINK_CYCLES+1) bits.

Reset
REQ-029 SHALL, while reset = 0 at a clk edge, clear mode, mac_q, cfg_valid, cfg_changed and led to 0.
REQ-030 SHALL, while reset = 0 at a clk edge, set synchroniser flops and debounced states to released (keys_n = 1, ext_mode = 0), clear all counters, and put the FSM in GAP.
REQ-031 SHALL, when reset is asserted mid-debounce or mid-blink, abandon the operation with no pulse emitted, restarting from the REQ-023 count.

Configuration
REQ-032 SHALL compile in the mode-count blink FSM of REQ-024..REQ-028 when macro LOCTAG_MODE_BLINK_EN is defined.
REQ-033 SHALL, when LOCTAG_MODE_BLINK_EN is not defined, omit the blink FSM and timer and drive led = cfg_valid registered, with reset value 0.

Verification (NUM_KEYS=4, MODE_W=2, DEBOUNCE_CYCLES=4, BLINK_CYCLES=2, macro defined)
REQ-034 SHALL cover: hold reset=0 for 3 cycles then release, inputs idle -> mode=00, mac_q=00, no cfg_changed; cfg_valid rises exactly 7 cycles after release.
REQ-035 SHALL cover: after cfg_valid, keys_n 1111->1101 held -> mode=10 exactly 7 cycles later, with one cfg_changed pulse.
REQ-036 SHALL cover: keys_n[0] low for 3 cycles then high -> mode, mac_q and cfg_changed unchanged.
REQ-037 SHALL cover: keys idle, ext_mode 0->1 -> mode=11 after 7 cycles; then keys_n=1110 -> mode=01, with ext_mode overridden.
REQ-038 SHALL cover: mode=10 steady -> led period = 8 cycles gap then 3 ON pulses of 2 cycles each separated by 2 OFF cycles, repeating; a key change mid-burst restarts from GAP.
REQ-039 SHALL cover: macro undefined -> led = 0 until cfg_valid, then constant 1; reset=0 mid-run -> led = 0 on the next edge.
